// File: rtl/cache_line_bus_bridge.sv
// cache_line_bus_bridge: moves one 64-byte cache line between the data cache
// and the system bus as a tagged request followed by eight 64-bit beats.
// Optional build macro CACHE_CRITICAL_WORD_FIRST_EN: read requests keep the
// requested word offset and response beats are stored starting at that slot.
module cache_line_bus_bridge #(
  parameter int                 LINE_BITS = 512,
  parameter int                 BUS_WIDTH = 64,
  parameter int                 TAG_WIDTH = 13,
  parameter logic [TAG_WIDTH-1:0] READ_TAG  = 13'h1100,
  parameter logic [TAG_WIDTH-1:0] WRITE_TAG = 13'h0101
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 addr_data_enable,
  input  logic                 rd_wr,
  input  logic [63:0]          phy_addr,
  input  logic [LINE_BITS-1:0] data_in,
  output logic [LINE_BITS-1:0] data_out,
  output logic                 addr_data_ready,
  output logic                 busy,
  output logic                 bus_reqcyc,
  output logic [BUS_WIDTH-1:0] bus_req,
  output logic [TAG_WIDTH-1:0] bus_reqtag,
  input  logic                 bus_reqack,
  input  logic                 bus_respcyc,
  input  logic [BUS_WIDTH-1:0] bus_resp,
  input  logic [TAG_WIDTH-1:0] bus_resptag,
  output logic                 bus_respack
);

  localparam int BEATS = LINE_BITS / BUS_WIDTH;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);
  localparam logic [63:0]   LINE_MASK = 64'h3F;
  localparam logic [63:0]   WORD_MASK = 64'h7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_RESP = 3'd2,
    WR_REQ  = 3'd3,
    WR_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t               state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [CW-1:0]        start_reg;
  logic [BUS_WIDTH-1:0] wr_beat_reg [BEATS];
  logic [BUS_WIDTH-1:0] rd_beat_reg [BEATS];
  logic [LINE_BITS-1:0] line_next;
  logic [63:0]          rd_addr;
  logic [63:0]          wr_addr;
  logic [CW-1:0]        start_next;
  logic [CW-1:0]        slot;
  logic                 accept;
  logic                 resp_fire;
  logic                 last_beat;

  // Writebacks always start at the line base.
  assign wr_addr = phy_addr & ~LINE_MASK;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  // Ask for the missing word first; the bus returns the line wrapping from it.
  assign rd_addr    = phy_addr & ~WORD_MASK;
  assign start_next = phy_addr[5:3];
`else
  assign rd_addr    = phy_addr & ~LINE_MASK;
  assign start_next = '0;
`endif

  assign accept      = (state_reg == IDLE) && addr_data_enable;
  assign resp_fire   = (state_reg == RD_RESP) && bus_respcyc && (bus_resptag == READ_TAG);
  assign bus_respack = resp_fire;
  assign slot        = start_reg + cnt_reg;
  assign last_beat   = (cnt_reg == CNT_LAST);

  // Per-slot beat storage; line_next is the line including the beat arriving now,
  // so data_out can be published at the same edge that stores the last beat.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
      // Capture writeback beat gi when the transaction is accepted
      always_ff @(posedge clk) begin
        if (accept && rd_wr) begin
          wr_beat_reg[gi] <= data_in[gi*BUS_WIDTH +: BUS_WIDTH];
        end
      end

      // Store a matching read response beat destined for slot gi
      always_ff @(posedge clk) begin
        if (resp_fire && (slot == CW'(gi))) begin
          rd_beat_reg[gi] <= bus_resp;
        end
      end

      assign line_next[gi*BUS_WIDTH +: BUS_WIDTH] =
        (resp_fire && (slot == CW'(gi))) ? bus_resp : rd_beat_reg[gi];
    end
  endgenerate

  // Transaction FSM with registered bus and handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      start_reg       <= '0;
      data_out        <= '0;
      addr_data_ready <= 1'b0;
      busy            <= 1'b0;
      bus_reqcyc      <= 1'b0;
      bus_req         <= '0;
      bus_reqtag      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          addr_data_ready <= 1'b0;
          if (addr_data_enable) begin
            busy       <= 1'b1;
            bus_reqcyc <= 1'b1;
            cnt_reg    <= '0;
            if (rd_wr) begin
              state_reg  <= WR_REQ;
              bus_req    <= wr_addr;
              bus_reqtag <= WRITE_TAG;
            end else begin
              state_reg  <= RD_REQ;
              bus_req    <= rd_addr;
              bus_reqtag <= READ_TAG;
              start_reg  <= start_next;
            end
          end
        end
        RD_REQ: begin
          if (bus_reqack) begin
            state_reg  <= RD_RESP;
            bus_reqcyc <= 1'b0;
            bus_req    <= '0;
            bus_reqtag <= '0;
          end
        end
        RD_RESP: begin
          if (resp_fire) begin
            cnt_reg <= cnt_reg + CNT_ONE;
            if (last_beat) begin
              state_reg       <= DONE;
              data_out        <= line_next;
              addr_data_ready <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (bus_reqack) begin
            state_reg <= WR_DATA;
            bus_req   <= wr_beat_reg[0];
          end
        end
        WR_DATA: begin
          if (bus_reqack) begin
            cnt_reg <= cnt_reg + CNT_ONE;
            if (last_beat) begin
              state_reg       <= DONE;
              bus_reqcyc      <= 1'b0;
              bus_req         <= '0;
              bus_reqtag      <= '0;
              addr_data_ready <= 1'b1;
            end else begin
              bus_req <= wr_beat_reg[cnt_reg + CNT_ONE];
            end
          end
        end
        DONE: begin
          addr_data_ready <= 1'b0;
          busy            <= 1'b0;
          state_reg       <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_bus_bridge.sv
// Testbench for cache_line_bus_bridge: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the bridge.
module tb_cache_line_bus_bridge;

  localparam logic [12:0] RT = 13'h1100;
  localparam logic [12:0] WT = 13'h0101;

  logic         clk = 1'b0;
  logic         reset;
  logic         addr_data_enable;
  logic         rd_wr;
  logic [63:0]  phy_addr;
  logic [511:0] data_in;
  logic [511:0] data_out;
  logic         addr_data_ready;
  logic         busy;
  logic         bus_reqcyc;
  logic [63:0]  bus_req;
  logic [12:0]  bus_reqtag;
  logic         bus_reqack;
  logic         bus_respcyc;
  logic [63:0]  bus_resp;
  logic [12:0]  bus_resptag;
  logic         bus_respack;

  always #5 clk = ~clk;

  cache_line_bus_bridge dut (
    .clk              (clk),
    .reset            (reset),
    .addr_data_enable (addr_data_enable),
    .rd_wr            (rd_wr),
    .phy_addr         (phy_addr),
    .data_in          (data_in),
    .data_out         (data_out),
    .addr_data_ready  (addr_data_ready),
    .busy             (busy),
    .bus_reqcyc       (bus_reqcyc),
    .bus_req          (bus_req),
    .bus_reqtag       (bus_reqtag),
    .bus_reqack       (bus_reqack),
    .bus_respcyc      (bus_respcyc),
    .bus_resp         (bus_resp),
    .bus_resptag      (bus_resptag),
    .bus_respack      (bus_respack)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Observation log filled while sampling
  int          ready_count;
  int          first_ready;
  logic [63:0] req_log[$];
  logic        s_respack;

  // Transaction-level model: one line transfer in flight at most
  bit          m_valid  = 0;
  bit          m_active = 0;
  bit          m_write  = 0;
  bit          m_addr_ph = 0;
  bit          m_done   = 0;
  int          m_beats  = 0;
  int          m_off    = 0;
  logic [63:0] m_addr;
  logic [63:0] m_wdata [8];
  logic [63:0] m_tmp   [8];
  logic [511:0] m_line = '0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    bit er;
    bit erack;
    if (!m_valid) return;
    er    = m_active && !m_done && (m_addr_ph || (m_write && m_beats < 8));
    erack = m_active && !m_write && !m_addr_ph && !m_done &&
            bus_respcyc && (bus_resptag == RT);
    chk("busy", {511'd0, busy}, {511'd0, m_active});
    chk("ready", {511'd0, addr_data_ready}, {511'd0, m_done});
    chk("reqcyc", {511'd0, bus_reqcyc}, {511'd0, er});
    chk("respack", {511'd0, bus_respack}, {511'd0, erack});
    if (er) begin
      chk("req", {448'd0, bus_req}, {448'd0, (m_addr_ph ? m_addr : m_wdata[m_beats])});
      chk("reqtag", {499'd0, bus_reqtag}, {499'd0, (m_write ? WT : RT)});
    end
    chk("data_out", data_out, m_line);
  endtask

  task automatic model_step();
    if (reset) begin
      m_valid = 1; m_active = 0; m_done = 0; m_addr_ph = 0; m_beats = 0;
      m_line = '0;
    end else if (!m_valid) begin
      m_valid = 0;
    end else if (!m_active) begin
      if (addr_data_enable) begin
        m_active = 1; m_write = rd_wr; m_addr_ph = 1; m_beats = 0; m_done = 0;
        if (rd_wr) begin
          m_addr = phy_addr & ~64'h3F;
          for (int i = 0; i < 8; i++) m_wdata[i] = data_in[64*i +: 64];
        end else begin
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
          m_addr = phy_addr & ~64'h7;
          m_off  = int'((phy_addr >> 3) % 64'd8);
`else
          m_addr = phy_addr & ~64'h3F;
          m_off  = 0;
`endif
        end
      end
    end else if (m_done) begin
      m_active = 0; m_done = 0;
    end else if (m_addr_ph) begin
      if (bus_reqack) m_addr_ph = 0;
    end else if (m_write) begin
      if (bus_reqack) begin
        m_beats++;
        if (m_beats == 8) m_done = 1;
      end
    end else if (bus_respcyc && bus_resptag == RT) begin
      m_tmp[(m_off + m_beats) % 8] = bus_resp;
      m_beats++;
      if (m_beats == 8) begin
        m_done = 1;
        for (int i = 0; i < 8; i++) m_line[64*i +: 64] = m_tmp[i];
      end
    end
  endtask

  // One clock cycle: sample and check mid-cycle, then advance the model at the edge
  task automatic tick();
    #1;
    check_outputs();
    if (m_valid && addr_data_ready === 1'b1) begin
      ready_count++;
      if (first_ready < 0) first_ready = cyc;
      $display("txn complete cycle %0d: %s data_out[63:0]=%h", cyc,
               m_write ? "writeback" : "fill", data_out[63:0]);
    end
    if (bus_reqcyc === 1'b1 && bus_reqack) req_log.push_back(bus_req);
    s_respack = bus_respack;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_log();
    ready_count = 0;
    first_ready = -1;
    req_log.delete();
  endtask

  // Read with immediate ack and eight back-to-back matching responses
  task automatic run_read(input logic [63:0] pa, input logic [63:0] base, output int t0);
    clear_log();
    t0 = cyc;
    addr_data_enable = 1; rd_wr = 0; phy_addr = pa; bus_reqack = 1;
    tick();
    addr_data_enable = 0;
    tick();
    for (int k = 0; k < 8; k++) begin
      bus_respcyc = 1; bus_resptag = RT; bus_resp = base + 64'(k);
      tick();
    end
    bus_respcyc = 0; bus_reqack = 0;
    repeat (3) tick();
  endtask

  initial begin
    int t0;
    int b;
    bit pat [14];
    logic [63:0] exp_slot [8];

    reset = 1; addr_data_enable = 0; rd_wr = 0; phy_addr = '0; data_in = '0;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
    clear_log();
    @(negedge clk);
    tick();
    tick();
    reset = 0;

    // Reset state
    chk("rst_busy", {511'd0, busy}, 512'd0);
    chk("rst_ready", {511'd0, addr_data_ready}, 512'd0);
    chk("rst_reqcyc", {511'd0, bus_reqcyc}, 512'd0);
    chk("rst_req", {448'd0, bus_req}, 512'd0);
    chk("rst_reqtag", {499'd0, bus_reqtag}, 512'd0);
    chk("rst_data_out", data_out, 512'd0);

    // Fill read at minimum latency
    run_read(64'h8040_0013, 64'h1000, t0);
    chk("t1_ready_cycle", 512'(first_ready - t0), 512'd10);
    chk("t1_ready_pulses", 512'(ready_count), 512'd1);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    chk("t1_req_addr", {448'd0, req_log[0]}, {448'd0, 64'h8040_0010});
    exp_slot = '{64'h1006, 64'h1007, 64'h1000, 64'h1001, 64'h1002, 64'h1003, 64'h1004, 64'h1005};
`else
    chk("t1_req_addr", {448'd0, req_log[0]}, {448'd0, 64'h8040_0000});
    exp_slot = '{64'h1000, 64'h1001, 64'h1002, 64'h1003, 64'h1004, 64'h1005, 64'h1006, 64'h1007};
`endif
    for (int s = 0; s < 8; s++) chk("t1_slot", {448'd0, data_out[64*s +: 64]}, {448'd0, exp_slot[s]});

    // Writeback with stalls on the address phase and between beats 4 and 5
    clear_log();
    for (int i = 0; i < 8; i++) data_in[64*i +: 64] = 64'hA0 + 64'(i);
    rd_wr = 1; phy_addr = 64'h1234_5678_9ABC_DEFF; addr_data_enable = 1; bus_reqack = 0;
    tick();
    addr_data_enable = 0;
    for (int i = 0; i < 16; i++) data_in[32*i +: 32] = $urandom;
    pat = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
    for (int j = 0; j < 14; j++) begin
      bus_reqack = pat[j];
      tick();
    end
    bus_reqack = 0;
    repeat (3) tick();
    chk("t2_req_count", 512'(req_log.size()), 512'd9);
    if (req_log.size() == 9) begin
      chk("t2_addr", {448'd0, req_log[0]}, {448'd0, 64'h1234_5678_9ABC_DEC0});
      for (int i = 0; i < 8; i++) chk("t2_beat", {448'd0, req_log[1+i]}, {448'd0, 64'hA0 + 64'(i)});
    end
    chk("t2_ready_pulses", 512'(ready_count), 512'd1);
    chk("t2_data_out_kept", {448'd0, data_out[63:0]}, {448'd0, exp_slot[0]});

    // Mismatched tag mid-burst, enable held through the response and done phases
    clear_log();
    rd_wr = 0; phy_addr = 64'h40; addr_data_enable = 1; bus_reqack = 1;
    tick();
    tick();
    b = 0;
    for (int j = 0; j < 9; j++) begin
      bus_respcyc = 1;
      if (j == 4) begin
        bus_resptag = WT; bus_resp = 64'hDEAD;
        tick();
        chk("t3_mismatch_respack", {511'd0, s_respack}, 512'd0);
      end else begin
        bus_resptag = RT; bus_resp = 64'h2000 + 64'(b);
        b++;
        tick();
      end
    end
    bus_respcyc = 0;
    tick();
    addr_data_enable = 0; bus_reqack = 0;
    repeat (3) tick();
    chk("t3_req_count", 512'(req_log.size()), 512'd1);
    chk("t3_ready_pulses", 512'(ready_count), 512'd1);
    for (int s = 0; s < 8; s++) chk("t3_slot", {448'd0, data_out[64*s +: 64]}, {448'd0, 64'h2000 + 64'(s)});

    // Reset after beat 3 of a read
    clear_log();
    rd_wr = 0; phy_addr = 64'h3000; addr_data_enable = 1; bus_reqack = 1;
    tick();
    addr_data_enable = 0;
    tick();
    for (int k = 0; k < 4; k++) begin
      bus_respcyc = 1; bus_resptag = RT; bus_resp = 64'h3000 + 64'(k);
      tick();
    end
    reset = 1; bus_resp = 64'h3004;
    tick();
    reset = 0; bus_respcyc = 0; bus_reqack = 0;
    chk("t4_busy", {511'd0, busy}, 512'd0);
    chk("t4_reqcyc", {511'd0, bus_reqcyc}, 512'd0);
    chk("t4_req", {448'd0, bus_req}, 512'd0);
    chk("t4_respack", {511'd0, bus_respack}, 512'd0);
    chk("t4_data_out", data_out, 512'd0);
    repeat (3) tick();
    chk("t4_no_ready", 512'(ready_count), 512'd0);
    run_read(64'h5000, 64'h3100, t0);
    chk("t4_after_ready", 512'(ready_count), 512'd1);
    for (int s = 0; s < 8; s++) chk("t4_slot", {448'd0, data_out[64*s +: 64]}, {448'd0, 64'h3100 + 64'(s)});

    // Critical-word-first placement (offset 6)
    run_read(64'h7030, 64'hB0, t0);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    exp_slot = '{64'hB2, 64'hB3, 64'hB4, 64'hB5, 64'hB6, 64'hB7, 64'hB0, 64'hB1};
`else
    exp_slot = '{64'hB0, 64'hB1, 64'hB2, 64'hB3, 64'hB4, 64'hB5, 64'hB6, 64'hB7};
`endif
    for (int s = 0; s < 8; s++) chk("t5_slot", {448'd0, data_out[64*s +: 64]}, {448'd0, exp_slot[s]});

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset            = ($urandom_range(0, 399) == 0);
      addr_data_enable = ($urandom_range(0, 3) == 0);
      rd_wr            = $urandom_range(0, 1) == 1;
      phy_addr         = {$urandom, $urandom};
      for (int i = 0; i < 16; i++) data_in[32*i +: 32] = $urandom;
      bus_reqack       = ($urandom_range(0, 2) != 0);
      bus_respcyc      = ($urandom_range(0, 2) != 0);
      bus_resp         = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       bus_resptag = WT;
        1:       bus_resptag = 13'($urandom);
        default: bus_resptag = RT;
      endcase
      tick();
    end
    reset = 0; addr_data_enable = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cache_line_bus_bridge.md
Name: cache_line_bus_bridge

Overview:
- Memory-side stage directly downstream of the set-associative data cache.
- Accepts one 64-byte line transaction at a time from the cache's miss/flush path: a fill read or a dirty-line writeback.
- Converts each transaction into a tagged request plus 8 x 64-bit beats on the system bus, and returns a one-cycle completion strobe.
- On a read, also returns the assembled 512-bit line to the cache.

Parameters:
- LINE_BITS, 512, cache line width in bits. Fixed by the cache geometry.
- BUS_WIDTH, 64, bus beat width. BEATS = LINE_BITS/BUS_WIDTH = 8 is a derived localparam.
- TAG_WIDTH, 13, width of the bus request and response tags.
- READ_TAG, 13'h1100, tag driven on read requests and matched on read responses.
- WRITE_TAG, 13'h0101, tag driven on writeback requests.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- addr_data_enable  in  1  one-cycle request strobe from the cache.
- rd_wr  in  1  0 = line fill (read), 1 = writeback.
- phy_addr  in  64  line address.
- data_in  in  512  writeback line; beat i is bits [64i+63:64i].
- data_out  out  512  filled line, same beat ordering as data_in.
- addr_data_ready  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state is not IDLE.
- bus_reqcyc  out  1  bus request valid.
- bus_req  out  64  request address or write beat.
- bus_reqtag  out  13  request tag.
- bus_reqack  in  1  request accepted this cycle.
- bus_respcyc  in  1  response beat valid.
- bus_resp  in  64  response data.
- bus_resptag  in  13  response tag.
- bus_respack  out  1  response beat consumed this cycle (combinational).

Behaviour:
- States: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_DATA, DONE. 3-bit beat counter cnt.
- Reset:
  - state=IDLE, cnt=0, data_out=0.
  - All outputs 0: addr_data_ready, busy, bus_reqcyc, bus_req, bus_reqtag, bus_respack.
  - Reset mid-transaction aborts it with no ready pulse. Beats already on the bus are not retracted.
- IDLE:
  - On addr_data_enable=1, latch addr = {phy_addr[63:6], 6'b0} and, if writing, latch data_in.
  - Go to RD_REQ (rd_wr=0) or WR_REQ (rd_wr=1), with cnt=0.
  - addr_data_enable is ignored in every other state, including DONE.
- RD_REQ:
  - Drive bus_reqcyc=1, bus_req=addr, bus_reqtag=READ_TAG.
  - Hold these stable until bus_reqack=1, then go to RD_RESP.
- RD_RESP:
  - On a cycle with bus_respcyc=1 and bus_resptag==READ_TAG: bus_respack=1 in the same cycle, store the beat at line slot cnt, cnt++.
  - When the 8th beat is stored, go to DONE.
  - Non-matching tags or idle cycles: bus_respack=0, no state change.
- WR_REQ:
  - Drive bus_reqcyc=1, bus_req=addr, bus_reqtag=WRITE_TAG until bus_reqack=1, then go to WR_DATA.
- WR_DATA:
  - Drive bus_reqcyc=1, bus_req=beat[cnt], bus_reqtag=WRITE_TAG.
  - Each bus_reqack advances cnt. After the 8th ack, go to DONE.
- DONE:
  - addr_data_ready=1 for exactly one cycle, then go to IDLE.
  - For a read, data_out is updated at the same edge that enters DONE. It holds its value until the next read completes; writes never modify it.
- bus_respack is 0 outside RD_RESP.
- Minimum latency (bus acks and responses every cycle): enable in cycle 0 gives addr_data_ready in cycle 10, for both reads and writes. The earliest next enable is accepted in cycle 11.
- cnt wraps 7 -> 0 only on the transition to DONE.

Optional Feature:
- Macro: CACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Read requests keep phy_addr[5:3]: bus_req = {phy_addr[63:6], phy_addr[5:3], 3'b0}.
  - Response beat k is stored at line slot (phy_addr[5:3]+k) mod 8, wrapping 7 -> 0.
  - Writebacks remain aligned and start at beat 0.
- Undefined: read addresses are aligned and beat k is stored at slot k.

Test Plan:
- Read, bus ack immediate, responses 64'h1000+k for k=0..7 on consecutive cycles, phy_addr=64'h8040_0013 -> bus_req=64'h8040_0000 with tag READ_TAG. addr_data_ready pulses exactly in cycle 10; data_out slot k = 64'h1000+k.
- Writeback, data_in slot i = 64'hA0+i, bus_reqack held low 3 cycles on the address phase and 2 cycles between beats 4 and 5 -> request fields held stable while stalled. Beats emitted in order A0..A7; one ready pulse.
- Read response with bus_resptag=WRITE_TAG interleaved mid-burst -> bus_respack=0 for that beat, cnt unchanged. Line still correct after 8 matching beats.
- addr_data_enable asserted during RD_RESP and during DONE -> ignored. busy stays 1 and no second bus request is issued.
- reset asserted after beat 3 of a read -> next cycle state IDLE, all outputs 0, data_out=0, no ready pulse. A subsequent read completes normally.
- With CACHE_CRITICAL_WORD_FIRST_EN, phy_addr[5:3]=3'd6 and responses B0..B7 -> slot 6=B0, slot 7=B1, slot 0=B2, ..., slot 5=B7.
